tpu_result_drain: RTL

- Downstream stage of the 2x2 systolic array and its feeder.
- When a matmul completes, snapshots the four 16-bit accumulations (c00, c01, c10, c11) into a 2-entry result buffer.
- Streams them to the host one byte per beat over a valid/ready handshake.
- A new matmul can therefore run while the previous result drains through the 8-bit output pins.

---
 rtl/tpu_drain_pkg.sv | 44 ++++
 rtl/result_fifo.sv | 66 ++++++
 rtl/tpu_result_drain.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tpu_drain_pkg.sv
// ============================================================================
// Module  : tpu_drain_pkg
// Brief   : Shared types, constants and the int8 clamp for the result drain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_drain_pkg;

    localparam int ACC_W      = 16;
    localparam int BYTES_FULL = 8;
    localparam int BYTES_SAT  = 4;
    localparam int ENTRY_W    = 4*ACC_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] c00;
        logic [ACC_W-1:0] c01;
        logic [ACC_W-1:0] c10;
        logic [ACC_W-1:0] c11;
        logic             mode;
    } entry_t;

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] c_sat_max;
        logic signed [ACC_W-1:0] c_sat_min;
        c_sat_max = 127;
        c_sat_min = -128;
        if (x > c_sat_max) begin
            return 8'h7F;
        end else if (x < c_sat_min) begin
            return 8'h80;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module  : result_fifo
// Brief   : Small synchronous FIFO exposing the head and the entry behind it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_next
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[r_rd_ptr + PTR_W'(1)];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/tpu_result_drain.sv
// ============================================================================
// Module  : tpu_result_drain
// Brief   : Buffers 2x2 matmul results and streams them out a byte per beat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_result_drain #(
    parameter int ACC_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             sat_mode,
    input  logic [ACC_W-1:0] c00,
    input  logic [ACC_W-1:0] c01,
    input  logic [ACC_W-1:0] c10,
    input  logic [ACC_W-1:0] c11,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_ovf
);

    import tpu_drain_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_out_data;
    logic [7:0]       w_out_data_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;

    entry_t           w_cap_entry;
    entry_t           w_head;
    entry_t           w_head_next;
    entry_t           w_next_entry;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_hs;
    logic             w_last;
    logic             w_pop;
    logic             w_push;
    logic             w_more;

    function automatic logic [7:0] pick_byte(input entry_t e, input logic [2:0] idx);
        logic [1:0]       sel;
        logic [ACC_W-1:0] word;
        sel = e.mode ? idx[1:0] : idx[2:1];
        case (sel)
            2'd0:    word = e.c00;
            2'd1:    word = e.c01;
            2'd2:    word = e.c10;
            default: word = e.c11;
        endcase
        if (e.mode) begin
            return sat8(word);
        end else begin
            return idx[0] ? word[15:8] : word[7:0];
        end
    endfunction

    assign w_cap_entry = {c00, c01, c10, c11, sat_mode};

    assign w_hs   = r_out_valid && out_ready;
    assign w_last = w_head.mode ? (r_idx == 3'(BYTES_SAT - 1))
                                : (r_idx == 3'(BYTES_FULL - 1));
    assign w_pop  = (r_state == SEND) && w_hs && w_last;
    assign w_push = capture && (!w_full || w_pop);

    // After the pop, the new head is either the queued second entry or the
    // capture arriving on this very edge into an otherwise empty buffer.
    assign w_more       = (w_count > CNT_W'(1)) || w_push;
    assign w_next_entry = (w_count > CNT_W'(1)) ? w_head_next : w_cap_entry;

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_cap_entry),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head),
        .head_next (w_head_next)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_overflow_nxt  = r_overflow;

        if (capture && !w_push) begin
            w_overflow_nxt = 1'b1;
        end else if (clr_ovf) begin
            w_overflow_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt     = SEND;
                    w_idx_nxt       = 3'd0;
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = pick_byte(w_head, 3'd0);
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_idx_nxt = 3'd0;
                        if (w_more) begin
                            w_out_data_nxt = pick_byte(w_next_entry, 3'd0);
                        end else begin
                            w_state_nxt     = IDLE;
                            w_out_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_idx_nxt      = r_idx + 3'd1;
                        w_out_data_nxt = pick_byte(w_head, r_idx + 3'd1);
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 3'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign busy      = (w_count != '0) || r_out_valid;

endmodule

`default_nettype wire
